decoded_op_queue: RTL and testbench



---
 rtl/decoded_op_queue_pkg.sv | 19 +
 rtl/decoded_op_queue_compactor.sv | 25 ++
 rtl/decoded_op_queue.sv | 105 ++++++++++
 tb/tb_decoded_op_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoded_op_queue_pkg.sv
// Shared types and default sizes for the decode-to-rename micro-op queue.
package decoded_op_queue_pkg;

  localparam int DECODE_WIDTH           = 2;
  localparam int RENAME_WIDTH           = 2;
  localparam int DECODED_OP_QUEUE_DEPTH = 8;

  typedef logic [$clog2(DECODED_OP_QUEUE_DEPTH)-1:0] DecodedOpQueueIndexPath;
  typedef logic [$clog2(DECODED_OP_QUEUE_DEPTH):0]   DecodedOpQueueCountPath;

  // Micro-op payload carried from decode to rename.
  typedef struct packed {
    logic [15:0] opInfo;
    logic [31:0] pc;
    logic        bPred;
    logic [7:0]  opId;
  } RenameStageRegPath;

endpackage

// File: rtl/decoded_op_queue_compactor.sv
// Prefix popcount over the enqueue lanes: each lane gets the number of valid
// lanes below it (its write offset from tail), plus the total valid count.
module decoded_op_compactor #(
  parameter  int WIDTH = 2,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] valid,
  output logic [CNT_W-1:0] offset [WIDTH],
  output logic [CNT_W-1:0] total
);

  // Running sum across lanes in ascending order.
  always_comb begin
    logic [CNT_W-1:0] run;
    // NOTE: blocking assignments here are deliberate; each lane must see the
    // running sum already updated by all lower lanes within the same pass.
    run = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = run;
      run       = run + CNT_W'(valid[i]);
    end
    total = run;
  end

endmodule

// File: rtl/decoded_op_queue.sv
// In-order micro-op buffer between decode and rename. Valid decode lanes are
// compacted into a circular buffer; up to RENAME_WIDTH oldest entries are
// presented each cycle and consumed together unless rename stalls.
module decoded_op_queue
  import decoded_op_queue_pkg::*;
#(
  parameter int DECODE_WIDTH = decoded_op_queue_pkg::DECODE_WIDTH,
  parameter int RENAME_WIDTH = decoded_op_queue_pkg::RENAME_WIDTH,
  parameter int DEPTH        = DECODED_OP_QUEUE_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [DECODE_WIDTH-1:0]   enqValid,
  input  RenameStageRegPath         enqData [DECODE_WIDTH],
  output logic                      enqReady,
  output logic [RENAME_WIDTH-1:0]   deqValid,
  output RenameStageRegPath         deqData [RENAME_WIDTH],
  input  logic                      deqStall,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(DECODE_WIDTH + 1);

  RenameStageRegPath storage [DEPTH];
  logic [IDX_W-1:0]  head_ptr;
  logic [IDX_W-1:0]  tail_ptr;

  logic [OFF_W-1:0]  enq_off [DECODE_WIDTH];
  logic [OFF_W-1:0]  enq_n;
  logic [CNT_W-1:0]  deq_n;
  logic [CNT_W-1:0]  enq_acc;
  logic [CNT_W-1:0]  deq_acc;
  logic              do_enq;

  decoded_op_compactor #(.WIDTH(DECODE_WIDTH)) u_compactor (
    .valid  (enqValid),
    .offset (enq_off),
    .total  (enq_n)
  );

  // Ready and dequeue width depend on the registered count only, so no input
  // reaches an output combinationally.
  always_comb begin
    // NOTE: every output of this block gets a value before any condition is
    // evaluated, so no path can leave one unassigned and infer a latch.
    enqReady = (CNT_W'(DEPTH) - count) >= CNT_W'(DECODE_WIDTH);
    empty    = (count == '0);
    deq_n    = (count < CNT_W'(RENAME_WIDTH)) ? count : CNT_W'(RENAME_WIDTH);
    do_enq   = enqReady && !flush;
    enq_acc  = do_enq ? CNT_W'(enq_n) : '0;
    deq_acc  = (!deqStall && !flush) ? deq_n : '0;
  end

  // Present the oldest entries in order; the index wraps modulo DEPTH.
  always_comb begin
    deqValid = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      deqValid[i] = CNT_W'(i) < deq_n;
      deqData[i]  = storage[head_ptr + IDX_W'(i)];
    end
  end

  // Write valid lanes at their compacted offsets from tail.
  // NOTE: the payload array has no reset; occupancy is tracked by the
  // pointers and count, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (do_enq && enqValid[i]) begin
        storage[tail_ptr + IDX_W'(enq_off[i])] <= enqData[i];
      end
    end
  end

  // Pointer and occupancy update; flush wins over enqueue and dequeue.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge values of the others.
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      tail_ptr <= tail_ptr + IDX_W'(enq_acc);
      head_ptr <= head_ptr + IDX_W'(deq_acc);
      count    <= count + enq_acc - deq_acc;
    end
  end

  // Decode offering micro-ops while the queue is not ready is a protocol error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (enqReady || enq_n == '0)
        else $warning("decoded_op_queue: enqValid asserted while enqReady is low");
    end
  end

endmodule

// File: tb/tb_decoded_op_queue.sv
// Directed bench for decoded_op_queue: basic flow, hole compaction, full,
// wrap-around, flush priority and asynchronous reset.
module tb_decoded_op_queue;
  import decoded_op_queue_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [1:0]        enq_valid;
  RenameStageRegPath enq_data [2];
  logic              enq_ready;
  logic [1:0]        deq_valid;
  RenameStageRegPath deq_data [2];
  logic              deq_stall;
  logic [3:0]        count;
  logic              empty;

  int passed_checks = 0;
  int total_checks  = 0;

  decoded_op_queue dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .enqValid (enq_valid),
    .enqData  (enq_data),
    .enqReady (enq_ready),
    .deqValid (deq_valid),
    .deqData  (deq_data),
    .deqStall (deq_stall),
    .count    (count),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  function automatic RenameStageRegPath mk(input logic [7:0] tag);
    RenameStageRegPath p;
    p.opInfo = {8'hA5, tag};
    p.pc     = 32'h0000_1000 + {22'd0, tag, 2'b00};
    p.bPred  = tag[0];
    p.opId   = tag;
    return p;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [1:0] v, input logic [7:0] t0, input logic [7:0] t1);
    enq_valid   = v;
    enq_data[0] = mk(t0);
    enq_data[1] = mk(t1);
    step();
    enq_valid = 2'b00;
  endtask

  task automatic test_reset();
    total_checks++;
    if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else passed_checks++;
    total_checks++;
    if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed_checks++;
    total_checks++;
    if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b want 1", enq_ready); else passed_checks++;
    total_checks++;
    if (deq_valid !== 2'b00) $display("FAIL reset_deq_valid: got %b want 00", deq_valid); else passed_checks++;
  endtask

  task automatic test_basic();
    deq_stall = 1'b0;
    enq(2'b11, 8'h0A, 8'h0B);
    total_checks++;
    if (deq_valid !== 2'b11) $display("FAIL basic_deq_valid: got %b want 11", deq_valid); else passed_checks++;
    total_checks++;
    if (deq_data[0] !== mk(8'h0A)) $display("FAIL basic_lane0: got %h want %h", deq_data[0], mk(8'h0A)); else passed_checks++;
    total_checks++;
    if (deq_data[1] !== mk(8'h0B)) $display("FAIL basic_lane1: got %h want %h", deq_data[1], mk(8'h0B)); else passed_checks++;
    total_checks++;
    if (count !== 4'd2) $display("FAIL basic_count: got %0d want 2", count); else passed_checks++;
    step();
    total_checks++;
    if (count !== 4'd0 || empty !== 1'b1) $display("FAIL basic_drained: got count %0d empty %b want 0 1", count, empty); else passed_checks++;
  endtask

  task automatic test_holes();
    deq_stall = 1'b1;
    enq(2'b10, 8'h00, 8'h0C);
    enq(2'b01, 8'h0D, 8'h00);
    total_checks++;
    if (deq_valid !== 2'b11 || count !== 4'd2) $display("FAIL holes_occupancy: got valid %b count %0d want 11 2", deq_valid, count); else passed_checks++;
    total_checks++;
    if (deq_data[0] !== mk(8'h0C)) $display("FAIL holes_lane0: got %h want %h", deq_data[0], mk(8'h0C)); else passed_checks++;
    total_checks++;
    if (deq_data[1] !== mk(8'h0D)) $display("FAIL holes_lane1: got %h want %h", deq_data[1], mk(8'h0D)); else passed_checks++;
    deq_stall = 1'b0;
    step();
  endtask

  task automatic test_full();
    deq_stall = 1'b1;
    for (int k = 0; k < 4; k++) enq(2'b11, 8'(8'h10 + 2*k), 8'(8'h11 + 2*k));
    total_checks++;
    if (count !== 4'd8 || enq_ready !== 1'b0) $display("FAIL full_state: got count %0d ready %b want 8 0", count, enq_ready); else passed_checks++;
    total_checks++;
    if (deq_valid !== 2'b11) $display("FAIL full_deq_valid: got %b want 11", deq_valid); else passed_checks++;
    enq(2'b11, 8'h20, 8'h21);
    total_checks++;
    if (count !== 4'd8) $display("FAIL full_overflow_count: got %0d want 8", count); else passed_checks++;
    deq_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total_checks++;
      if (deq_valid !== 2'b11 || deq_data[0] !== mk(8'(8'h10 + 2*k)) || deq_data[1] !== mk(8'(8'h11 + 2*k)))
        $display("FAIL full_drain_%0d: got %b %h %h want 11 %h %h", k, deq_valid, deq_data[0], deq_data[1],
                 mk(8'(8'h10 + 2*k)), mk(8'(8'h11 + 2*k)));
      else passed_checks++;
      step();
    end
    total_checks++;
    if (count !== 4'd0) $display("FAIL full_drained: got %0d want 0", count); else passed_checks++;
  endtask

  task automatic test_wrap();
    // Move head and tail from 4 to 6.
    deq_stall = 1'b0;
    enq(2'b11, 8'h30, 8'h31);
    step();
    deq_stall = 1'b1;
    enq(2'b11, 8'h0E, 8'h0F);
    enq(2'b11, 8'h40, 8'h41);
    total_checks++;
    if (count !== 4'd4 || deq_data[0] !== mk(8'h0E) || deq_data[1] !== mk(8'h0F))
      $display("FAIL wrap_first: got %0d %h %h want 4 %h %h", count, deq_data[0], deq_data[1], mk(8'h0E), mk(8'h0F));
    else passed_checks++;
    deq_stall = 1'b0;
    step();
    total_checks++;
    if (count !== 4'd2 || deq_valid !== 2'b11 || deq_data[0] !== mk(8'h40) || deq_data[1] !== mk(8'h41))
      $display("FAIL wrap_second: got %0d %b %h %h want 2 11 %h %h", count, deq_valid, deq_data[0], deq_data[1], mk(8'h40), mk(8'h41));
    else passed_checks++;
    step();
    total_checks++;
    if (count !== 4'd0) $display("FAIL wrap_drained: got %0d want 0", count); else passed_checks++;
  endtask

  task automatic test_straddle();
    // Single-lane enqueue shifts alignment to odd: head/tail 2 -> 3.
    deq_stall = 1'b1;
    enq(2'b01, 8'h50, 8'h00);
    total_checks++;
    if (deq_valid !== 2'b01 || deq_data[0] !== mk(8'h50)) $display("FAIL straddle_single: got %b %h want 01 %h", deq_valid, deq_data[0], mk(8'h50)); else passed_checks++;
    deq_stall = 1'b0;
    step();
    deq_stall = 1'b1;
    enq(2'b11, 8'h51, 8'h52);
    enq(2'b11, 8'h53, 8'h54);
    enq(2'b11, 8'h55, 8'h56);  // slots 7 and 0
    total_checks++;
    if (count !== 4'd6) $display("FAIL straddle_count: got %0d want 6", count); else passed_checks++;
    deq_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total_checks++;
      if (deq_data[0] !== mk(8'(8'h51 + 2*k)) || deq_data[1] !== mk(8'(8'h52 + 2*k)))
        $display("FAIL straddle_read_%0d: got %h %h want %h %h", k, deq_data[0], deq_data[1], mk(8'(8'h51 + 2*k)), mk(8'(8'h52 + 2*k)));
      else passed_checks++;
      step();
    end
  endtask

  task automatic test_flush();
    deq_stall = 1'b1;
    enq(2'b11, 8'h60, 8'h61);
    enq(2'b10, 8'h00, 8'h62);
    total_checks++;
    if (count !== 4'd3) $display("FAIL flush_setup: got %0d want 3", count); else passed_checks++;
    flush       = 1'b1;
    deq_stall   = 1'b0;
    enq(2'b11, 8'h63, 8'h64);
    flush = 1'b0;
    total_checks++;
    if (count !== 4'd0 || empty !== 1'b1 || deq_valid !== 2'b00)
      $display("FAIL flush_result: got count %0d empty %b valid %b want 0 1 00", count, empty, deq_valid);
    else passed_checks++;
    deq_stall = 1'b1;
    enq(2'b10, 8'h00, 8'h65);
    total_checks++;
    if (count !== 4'd1 || deq_valid !== 2'b01 || deq_data[0] !== mk(8'h65))
      $display("FAIL flush_resume: got %0d %b %h want 1 01 %h", count, deq_valid, deq_data[0], mk(8'h65));
    else passed_checks++;
  endtask

  task automatic test_async_reset();
    deq_stall = 1'b1;
    enq(2'b11, 8'h70, 8'h71);
    enq(2'b11, 8'h72, 8'h73);
    total_checks++;
    if (count !== 4'd5) $display("FAIL areset_setup: got %0d want 5", count); else passed_checks++;
    #3 rst = 1'b1;
    #1;
    total_checks++;
    if (count !== 4'd0 || deq_valid !== 2'b00 || empty !== 1'b1 || enq_ready !== 1'b1)
      $display("FAIL areset_midcycle: got %0d %b %b %b want 0 00 1 1", count, deq_valid, empty, enq_ready);
    else passed_checks++;
    step();
    rst = 1'b0;
    enq(2'b11, 8'h7A, 8'h7B);
    total_checks++;
    if (count !== 4'd2 || deq_data[0] !== mk(8'h7A) || deq_data[1] !== mk(8'h7B))
      $display("FAIL areset_resume: got %0d %h %h want 2 %h %h", count, deq_data[0], deq_data[1], mk(8'h7A), mk(8'h7B));
    else passed_checks++;
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    enq_valid   = 2'b00;
    enq_data[0] = '0;
    enq_data[1] = '0;
    deq_stall   = 1'b0;
    #2;
    test_reset();
    step();
    rst = 1'b0;
    test_basic();
    test_holes();
    test_full();
    test_wrap();
    test_straddle();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
